// File: rtl/uart_cmd_engine.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_engine
//  Description : Serialises a command word onto a UART line, MS byte first.
//                Read commands then wait for a timed serial response, which
//                is returned on read_data with a parity/stop error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_engine #(
    parameter int CLK_DIV      = 434,
    parameter int CMD_WIDTH    = 16,
    parameter int READ_WIDTH   = 8,
    parameter int PARITY       = 2,
    parameter int GAP_BITS     = 2,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CMD_WIDTH-1:0]  cmd_in,
    input  logic                  cmd_vld,
    output logic                  cmd_rdy,
    input  logic                  rx,
    output logic                  tx,
    output logic                  read_vld,
    output logic [READ_WIDTH-1:0] read_data,
    output logic                  read_err,
    output logic                  rd_timeout
);

    localparam int CMD_BYTES = CMD_WIDTH / 8;
    localparam int RD_BYTES  = READ_WIDTH / 8;
    localparam int MAX_BYTES = (CMD_BYTES > RD_BYTES) ? CMD_BYTES : RD_BYTES;
    localparam int BAUD_W    = $clog2(CLK_DIV);
    localparam int BYTE_W    = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int GAP_W     = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam int TO_CYCLES = TIMEOUT_BITS * CLK_DIV;
    // Timeout keeps counting through rejected start candidates, so leave headroom.
    localparam int TO_W      = $clog2(TO_CYCLES + CLK_DIV + 1);

    localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BAUD_W-1:0] C_BAUD_HALF = BAUD_W'(CLK_DIV / 2 - 1);
    localparam logic [BYTE_W-1:0] C_CMD_LAST  = BYTE_W'(CMD_BYTES - 1);
    localparam logic [BYTE_W-1:0] C_RD_LAST   = BYTE_W'(RD_BYTES - 1);
    localparam logic [GAP_W-1:0]  C_GAP_LAST  = GAP_W'(GAP_BITS - 1);
    localparam logic [TO_W-1:0]   C_TO_LAST   = TO_W'(TO_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        TX_START = 4'd1,
        TX_DATA  = 4'd2,
        TX_PAR   = 4'd3,
        TX_STOP  = 4'd4,
        TX_GAP   = 4'd5,
        RX_WAIT  = 4'd6,
        RX_START = 4'd7,
        RX_DATA  = 4'd8,
        RX_PAR   = 4'd9,
        RX_STOP  = 4'd10,
        DONE     = 4'd11
    } state_t;

    state_t                r_state;
    logic [CMD_WIDTH-1:0]  r_cmd;
    logic                  r_is_write;
    logic [BAUD_W-1:0]     r_baud;
    logic [2:0]            r_bit;
    logic [BYTE_W-1:0]     r_byte;
    logic [GAP_W-1:0]      r_gap;
    logic [TO_W-1:0]       r_to_cnt;
    logic                  r_rx_s1;
    logic                  r_rx_s2;
    logic                  r_rx_prev;
    logic [7:0]            r_rx_byte;
    logic [READ_WIDTH-1:0] r_rd_shift;
    logic                  r_err;

    logic [7:0]            w_tx_byte;
    logic                  w_tx_par;
    logic                  w_rx_par_exp;
    logic                  w_baud_end;
    logic                  w_rx_fall;
    logic [READ_WIDTH-1:0] w_rd_next;

    assign cmd_rdy      = (r_state == IDLE);
    assign w_tx_byte    = r_cmd[CMD_WIDTH-1 -: 8];
    assign w_tx_par     = (PARITY == 1) ? ~^w_tx_byte : ^w_tx_byte;
    assign w_rx_par_exp = (PARITY == 1) ? ~^r_rx_byte : ^r_rx_byte;
    assign w_baud_end   = (r_baud == C_BAUD_LAST);
    assign w_rx_fall    = r_rx_prev & ~r_rx_s2;
    // First received byte ends up in the MS byte after all shifts.
    assign w_rd_next    = (r_rd_shift << 8) | READ_WIDTH'(r_rx_byte);

    // Two-flop synchroniser for rx, plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // Transaction state machine: transmit command, optionally receive reply.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            tx         <= 1'b1;
            read_vld   <= 1'b0;
            read_err   <= 1'b0;
            rd_timeout <= 1'b0;
            read_data  <= '0;
            r_cmd      <= '0;
            r_is_write <= 1'b0;
            r_baud     <= '0;
            r_bit      <= '0;
            r_byte     <= '0;
            r_gap      <= '0;
            r_to_cnt   <= '0;
            r_rx_byte  <= '0;
            r_rd_shift <= '0;
            r_err      <= 1'b0;
        end else begin
            read_vld   <= 1'b0;
            read_err   <= 1'b0;
            rd_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    tx <= 1'b1;
                    if (cmd_vld) begin
                        r_cmd      <= cmd_in;
                        r_is_write <= cmd_in[CMD_WIDTH-1];
                        r_baud     <= '0;
                        r_bit      <= '0;
                        r_byte     <= '0;
                        r_gap      <= '0;
                        r_err      <= 1'b0;
                        r_rd_shift <= '0;
                        tx         <= 1'b0;
                        r_state    <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        tx      <= w_tx_byte[0];
                        r_state <= TX_DATA;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                TX_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_bit <= '0;
                            if (PARITY != 0) begin
                                tx      <= w_tx_par;
                                r_state <= TX_PAR;
                            end else begin
                                tx      <= 1'b1;
                                r_state <= TX_STOP;
                            end
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            tx    <= w_tx_byte[r_bit + 3'd1];
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                TX_PAR: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        tx      <= 1'b1;
                        r_state <= TX_STOP;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                TX_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_byte == C_CMD_LAST) begin
                            // No gap after the final byte.
                            r_byte <= '0;
                            if (r_is_write) begin
                                r_state <= IDLE;
                            end else begin
                                r_to_cnt <= '0;
                                r_state  <= RX_WAIT;
                            end
                        end else begin
                            r_byte <= r_byte + BYTE_W'(1);
                            r_cmd  <= r_cmd << 8;
                            if (GAP_BITS == 0) begin
                                tx      <= 1'b0;
                                r_state <= TX_START;
                            end else begin
                                r_gap   <= '0;
                                r_state <= TX_GAP;
                            end
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                TX_GAP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_gap == C_GAP_LAST) begin
                            r_gap   <= '0;
                            tx      <= 1'b0;
                            r_state <= TX_START;
                        end else begin
                            r_gap <= r_gap + GAP_W'(1);
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                RX_WAIT: begin
                    if (r_to_cnt >= C_TO_LAST) begin
                        // Timeout shares DONE so cmd_rdy follows the pulse.
                        rd_timeout <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                        if (w_rx_fall) begin
                            // One cycle of the start bit has already elapsed.
                            r_baud  <= BAUD_W'(1);
                            r_state <= RX_START;
                        end
                    end
                end
                RX_START: begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                    if (r_baud == C_BAUD_HALF) begin
                        r_baud <= '0;
                        if (!r_rx_s2) begin
                            r_bit   <= '0;
                            r_state <= RX_DATA;
                        end else begin
                            r_state <= RX_WAIT;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                RX_DATA: begin
                    if (w_baud_end) begin
                        r_baud    <= '0;
                        r_rx_byte <= {r_rx_s2, r_rx_byte[7:1]};
                        if (r_bit == 3'd7) begin
                            r_bit <= '0;
                            if (PARITY != 0) begin
                                r_state <= RX_PAR;
                            end else begin
                                r_state <= RX_STOP;
                            end
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                RX_PAR: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_rx_s2 != w_rx_par_exp) begin
                            r_err <= 1'b1;
                        end
                        r_state <= RX_STOP;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                RX_STOP: begin
                    if (w_baud_end) begin
                        r_baud     <= '0;
                        r_rd_shift <= w_rd_next;
                        r_err      <= r_err | ~r_rx_s2;
                        if (r_byte == C_RD_LAST) begin
                            r_byte    <= '0;
                            read_data <= w_rd_next;
                            read_vld  <= 1'b1;
                            read_err  <= r_err | ~r_rx_s2;
                            r_state   <= DONE;
                        end else begin
                            r_byte   <= r_byte + BYTE_W'(1);
                            r_to_cnt <= '0;
                            r_state  <= RX_WAIT;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_cmd_engine
//  Description : Directed self-checking bench for uart_cmd_engine with
//                CLK_DIV=4, 16-bit commands, 8-bit reads, even parity.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_engine;

    localparam int CLK_DIV      = 4;
    localparam int CMD_WIDTH    = 16;
    localparam int READ_WIDTH   = 8;
    localparam int PARITY       = 2;
    localparam int GAP_BITS     = 2;
    localparam int TIMEOUT_BITS = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [CMD_WIDTH-1:0]  cmd_in = '0;
    logic                  cmd_vld = 1'b0;
    logic                  cmd_rdy;
    logic                  rx = 1'b1;
    logic                  tx;
    logic                  read_vld;
    logic [READ_WIDTH-1:0] read_data;
    logic                  read_err;
    logic                  rd_timeout;

    int errors = 0;
    int checks = 0;

    uart_cmd_engine #(
        .CLK_DIV      (CLK_DIV),
        .CMD_WIDTH    (CMD_WIDTH),
        .READ_WIDTH   (READ_WIDTH),
        .PARITY       (PARITY),
        .GAP_BITS     (GAP_BITS),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_in     (cmd_in),
        .cmd_vld    (cmd_vld),
        .cmd_rdy    (cmd_rdy),
        .rx         (rx),
        .tx         (tx),
        .read_vld   (read_vld),
        .read_data  (read_data),
        .read_err   (read_err),
        .rd_timeout (rd_timeout)
    );

    always #5 clk = ~clk;

    // Pulse cmd_vld for one edge; returns at the falling edge of cycle 0.
    task automatic issue_cmd(input logic [CMD_WIDTH-1:0] c);
        @(negedge clk);
        cmd_in  = c;
        cmd_vld = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
        cmd_in  = '0;
    endtask

    // Drive one response frame on rx: start, 8 data LSB first, parity, stop.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx = bits[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    // Collect the read completion (bounded wait); comparisons are done by callers.
    task automatic wait_read(output bit seen, output logic [7:0] data, output logic err,
                             output logic vld_next, output logic rdy_next, output bit to_seen);
        seen = 1'b0; to_seen = 1'b0; data = 'x; err = 1'bx; vld_next = 1'bx; rdy_next = 1'bx;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (rd_timeout) to_seen = 1'b1;
            if (read_vld) begin
                seen = 1'b1;
                data = read_data;
                err  = read_err;
            end
        end
        if (seen) begin
            @(negedge clk);
            vld_next = read_vld;
            rdy_next = cmd_rdy;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL reset_cmd_rdy: got %b expected 1", cmd_rdy); end
        checks++; if (read_vld !== 1'b0) begin errors++; $display("FAIL reset_read_vld: got %b expected 0", read_vld); end
        checks++; if (read_err !== 1'b0) begin errors++; $display("FAIL reset_read_err: got %b expected 0", read_err); end
        checks++; if (rd_timeout !== 1'b0) begin errors++; $display("FAIL reset_rd_timeout: got %b expected 0", rd_timeout); end
        checks++; if (read_data !== 8'h00) begin errors++; $display("FAIL reset_read_data: got %h expected 00", read_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Write 8A5C with cmd_vld held high (and cmd_in changed) while busy.
    task automatic test_write();
        logic [10:0] f0;
        logic [10:0] f1;
        logic        e;
        f0 = 11'b0_01010001_1_1;  // 0x8A, parity 1, sent left to right
        f1 = 11'b0_00111010_0_1;  // 0x5C, parity 0
        @(negedge clk);
        cmd_in  = 16'h8A5C;
        cmd_vld = 1'b1;
        @(negedge clk);
        cmd_in  = 16'h0000;
        for (int k = 0; k < 96; k++) begin
            if (k < 44)      e = f0[10 - k / 4];
            else if (k < 52) e = 1'b1;
            else             e = f1[10 - (k - 52) / 4];
            checks++;
            if (tx !== e) begin errors++; $display("FAIL write_tx cycle %0d: got %b expected %b", k, tx, e); end
            checks++;
            if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL write_busy_rdy cycle %0d: got %b expected 0", k, cmd_rdy); end
            if (k == 95) cmd_vld = 1'b0;
            @(negedge clk);
        end
        checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL write_done_rdy: got %b expected 1", cmd_rdy); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL write_done_tx: got %b expected 1", tx); end
    endtask

    // Read command, reply frame with given parity/stop; check completion.
    task automatic test_read(input string name, input logic [7:0] d, input logic p, input logic s,
                             input logic exp_err, input bit glitch);
        bit         seen;
        bit         to_seen;
        logic [7:0] data;
        logic       err;
        logic       vld_next;
        logic       rdy_next;
        issue_cmd(16'h1234);
        if (glitch) begin
            repeat (98) @(negedge clk);
            rx = 1'b0;
            @(negedge clk);
            rx = 1'b1;
            repeat (8) @(negedge clk);
        end else begin
            repeat (97) @(negedge clk);
        end
        fork
            send_frame(d, p, s);
            wait_read(seen, data, err, vld_next, rdy_next, to_seen);
        join
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL %s_vld_seen: got %b expected 1", name, seen); end
        checks++; if (data !== d) begin errors++; $display("FAIL %s_data: got %h expected %h", name, data, d); end
        checks++; if (err !== exp_err) begin errors++; $display("FAIL %s_err: got %b expected %b", name, err, exp_err); end
        checks++; if (vld_next !== 1'b0) begin errors++; $display("FAIL %s_vld_pulse: got %b expected 0", name, vld_next); end
        checks++; if (rdy_next !== 1'b1) begin errors++; $display("FAIL %s_rdy_after: got %b expected 1", name, rdy_next); end
        checks++; if (to_seen !== 1'b0) begin errors++; $display("FAIL %s_no_timeout: got %b expected 0", name, to_seen); end
        repeat (4) @(negedge clk);
    endtask

    // No reply: timeout pulse 32 cycles after RX_WAIT entry (cycle 96+32).
    task automatic test_timeout();
        int to_k;
        int rdy_k;
        int to_n;
        bit vld_seen;
        to_k = -1; rdy_k = -1; to_n = 0; vld_seen = 1'b0;
        issue_cmd(16'h0042);
        for (int k = 0; k <= 140; k++) begin
            if (k > 0) @(negedge clk);
            if (rd_timeout) begin
                to_n++;
                if (to_k < 0) to_k = k;
            end
            if (cmd_rdy && rdy_k < 0) rdy_k = k;
            if (read_vld) vld_seen = 1'b1;
        end
        checks++; if (to_k != 128) begin errors++; $display("FAIL timeout_cycle: got %0d expected 128", to_k); end
        checks++; if (to_n != 1) begin errors++; $display("FAIL timeout_width: got %0d expected 1", to_n); end
        checks++; if (rdy_k != 129) begin errors++; $display("FAIL timeout_rdy_cycle: got %0d expected 129", rdy_k); end
        checks++; if (vld_seen !== 1'b0) begin errors++; $display("FAIL timeout_no_vld: got %b expected 0", vld_seen); end
        checks++; if (read_data !== 8'h5A) begin errors++; $display("FAIL timeout_data_kept: got %h expected 5a", read_data); end
    endtask

    // Reset during a data bit of the first frame.
    task automatic test_reset_midframe();
        bit tx_bad;
        issue_cmd(16'h8A5C);
        repeat (12) @(negedge clk);
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midrst_pre_tx: got %b expected 0", tx); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b expected 1", tx); end
        checks++; if (read_data !== 8'h00) begin errors++; $display("FAIL midrst_read_data: got %h expected 00", read_data); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL midrst_rdy: got %b expected 1", cmd_rdy); end
        tx_bad = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || cmd_rdy !== 1'b1) tx_bad = 1'b1;
        end
        checks++; if (tx_bad !== 1'b0) begin errors++; $display("FAIL midrst_dropped: got %b expected 0", tx_bad); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read("read_ok", 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
        test_read("bad_parity", 8'hC3, 1'b1, 1'b1, 1'b1, 1'b0);
        test_read("bad_stop", 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
        test_timeout();
        test_read("glitch", 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1);
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
